// File: rtl/nrad_reconstructor.sv
// -----------------------------------------------------------------------------
// nrad_reconstructor
//
// Sequential radix-2 shift-and-add multiply-accumulate that rebuilds a dividend
// from a divider result: X = Q*Y + R. This is the inverse path of the
// non-restoring array divider. It is used to self-check divider outputs.
//
// One quotient bit is consumed per clock. The latency is fixed at WQ
// iterations, with no early exit for a zero multiplier. Operands are captured
// when start is accepted, so they may change while busy.
//
// Parameters:
//   WQ     quotient width (>= 1)
//   WY     divisor width (>= 1); the remainder has the same width
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; abandons any operation in flight
//   start  request, sampled only in IDLE
//   Q      quotient operand (multiplier)
//   Y      divisor operand (multiplicand)
//   R      remainder operand (accumulator seed)
//   X      reconstructed dividend; valid with done, held until the next accept
//   busy   high while iterating
//   done   one-cycle completion pulse
//   err    operand-consistency flag (Y==0 or R>=Y); informational only,
//          valid with done and held alongside X
// -----------------------------------------------------------------------------
module nrad_reconstructor #(
   parameter int WQ = 3,
   parameter int WY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WQ-1:0]    Q,
   input  logic [WY-1:0]    Y,
   input  logic [WY-1:0]    R,
   output logic [WQ+WY-1:0] X,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // The largest result is (2^WY-1)*2^WQ, which fits in WQ+WY bits.
   // The accumulator therefore needs no carry-out.
   localparam int WX = WQ + WY;
   localparam int CW = (WQ > 1) ? $clog2(WQ) : 1;
   localparam logic [CW-1:0] LAST = CW'(WQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [WX-1:0]   acc;
   logic [WX-1:0]   mcand;
   logic [WX-1:0]   acc_sum;
   logic [WQ-1:0]   mplier;
   logic [CW-1:0]   count;
   logic            err_r;

   logic            load;   // accept an operation this edge
   logic            step;   // perform one iteration this edge
   logic            last;   // this iteration is the final one

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. With
   // non-blocking assignments, every register samples pre-edge values,
   // regardless of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: each combinational output gets a default value before the case.
   // Otherwise, a path that does not assign it would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (count == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      load = 1'b0;
      step = 1'b0;
      last = 1'b0;
      case (state)
         IDLE: load = start;
         BUSY: begin
            step = 1'b1;
            last = (count == LAST);
         end
         default: ;
      endcase
   end

   // This is the partial-product add for the current multiplier LSB.
   // On the final iteration, this value is also the result.
   assign acc_sum = acc + (mplier[0] ? mcand : '0);

   // ---------------------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: every register here is reset, not just the control state. A reset
   // mid-operation then leaves no stale partial result that could leak into X.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         err_r  <= 1'b0;
         X      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         // done is high only on the edge that completes the final iteration.
         done <= last;

         if (load) begin
            acc    <= {{WQ{1'b0}}, R};
            mcand  <= {{WQ{1'b0}}, Y};
            mplier <= Q;
            count  <= '0;
            err_r  <= (Y == '0) | (R >= Y);
            busy   <= 1'b1;
         end

         if (step) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (last) begin
               X    <= acc_sum;
               err  <= err_r;
               busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_nrad_reconstructor.sv
// -----------------------------------------------------------------------------
// tb_nrad_reconstructor
//
// Directed self-checking bench for nrad_reconstructor with WQ=3 and WY=2.
// Inputs are driven on the falling edge and outputs are sampled there, away
// from the rising active edge. Expected values are hand-computed constants or
// the arithmetic Q*Y+R.
// -----------------------------------------------------------------------------
module tb_nrad_reconstructor;

   localparam int WQ = 3;
   localparam int WY = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WQ-1:0]    Q;
   logic [WY-1:0]    Y;
   logic [WY-1:0]    R;
   logic [WQ+WY-1:0] X;
   logic             busy;
   logic             done;
   logic             err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   nrad_reconstructor #(.WQ(WQ), .WY(WY)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .Q     (Q),
      .Y     (Y),
      .R     (R),
      .X     (X),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Call this at the falling edge right after the accept edge.
   // The bound of 20 keeps a missing done from hanging the run.
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input logic [WQ-1:0] q, input logic [WY-1:0] y, input logic [WY-1:0] r,
                        output logic [WQ+WY-1:0] x, output logic e, output int lat);
      @(negedge clk);
      Q = q; Y = y; R = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      x = X;
      e = err;
   endtask

   logic [WQ+WY-1:0] x;
   logic             e;
   int               lat;
   int               lat_bad;
   int               exp_x;
   int               done_at[$];
   int               done_x[$];
   logic             saw_done;

   initial begin
      reset = 1'b0; start = 1'b0; Q = '0; Y = '0; R = '0;
      #1 reset = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_x",    32'(X),    0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err",  32'(err),  0);
      reset = 1'b0;

      // Basic operation: 5*3+2 = 17, busy for 3 cycles, then a one-cycle done
      @(negedge clk);
      Q = 3'd5; Y = 2'd3; R = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t1_busy_c1", 32'(busy), 1);
      check("t1_done_c1", 32'(done), 0);
      @(negedge clk);
      check("t1_busy_c2", 32'(busy), 1);
      @(negedge clk);
      check("t1_busy_c3", 32'(busy), 1);
      check("t1_done_c3", 32'(done), 0);
      @(negedge clk);
      check("t1_done",    32'(done), 1);
      check("t1_busy_dn", 32'(busy), 0);
      check("t1_x",       32'(X),    17);
      check("t1_err",     32'(err),  0);
      @(negedge clk);
      check("t1_done_off", 32'(done), 0);
      check("t1_x_hold",   32'(X),    17);

      // Sweep over all consistent operands; err is packed above X as bit 5
      lat_bad = 0;
      for (int qi = 0; qi < 8; qi++)
         for (int yi = 1; yi < 4; yi++)
            for (int ri = 0; ri < yi; ri++) begin
               do_op(3'(qi), 2'(yi), 2'(ri), x, e, lat);
               exp_x = qi * yi + ri;
               check($sformatf("sweep q%0d y%0d r%0d", qi, yi, ri), 32'({e, x}), 32'(exp_x));
               if (lat != 4) lat_bad++;
            end
      check("sweep_latency", 32'(lat_bad), 0);

      do_op(3'd7, 2'd3, 2'd2, x, e, lat);
      check("max_x", 32'(x), 32'(5'b10111));

      // Error flag: Y == 0
      do_op(3'd4, 2'd0, 2'd1, x, e, lat);
      check("y0_x",   32'(x), 1);
      check("y0_err", 32'(e), 1);

      // Start held high; operands change every cycle. Accepts occur on edges
      // 0, 5 and 10, so only the operands driven just before those edges count.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_at.push_back(i);
            done_x.push_back(int'(X));
         end
         start = (i < 15);
         case (i)
            0:       begin Q = 3'd3; Y = 2'd2; R = 2'd1; end
            5:       begin Q = 3'd6; Y = 2'd3; R = 2'd2; end
            10:      begin Q = 3'd1; Y = 2'd2; R = 2'd0; end
            default: begin Q = 3'd7; Y = 2'd3; R = 2'd2; end
         endcase
      end
      start = 1'b0;
      check("b2b_count", 32'(done_at.size()), 3);
      if (done_at.size() == 3) begin
         check("b2b_first_at", 32'(done_at[0]), 4);
         check("b2b_gap1", 32'(done_at[1] - done_at[0]), 5);
         check("b2b_gap2", 32'(done_at[2] - done_at[1]), 5);
         check("b2b_x0", 32'(done_x[0]), 7);
         check("b2b_x1", 32'(done_x[1]), 20);
         check("b2b_x2", 32'(done_x[2]), 2);
      end

      // Error flag: R >= Y
      do_op(3'd2, 2'd2, 2'd3, x, e, lat);
      check("rgey_x",   32'(x), 7);
      check("rgey_err", 32'(e), 1);

      // Start during the DONE cycle is ignored; the next IDLE start is accepted
      Q = 3'd6; Y = 2'd1; R = 2'd0; start = 1'b1;
      @(negedge clk);
      check("dn_start_ignored", 32'(busy), 0);
      check("dn_x_hold",        32'(X),    7);
      check("dn_err_hold",      32'(err),  1);
      Q = 3'd1; Y = 2'd3; R = 2'd2;
      @(negedge clk);
      start = 1'b0;
      check("dn_next_busy",   32'(busy), 1);
      check("dn_x_hold_busy", 32'(X),    7);
      check("dn_err_hold_bz", 32'(err),  1);
      wait_done(lat);
      check("dn_next_x",   32'(X),   5);
      check("dn_next_err", 32'(err), 0);
      check("dn_next_lat", 32'(lat), 4);

      // Set nonzero X and err so the asynchronous reset visibly clears them
      do_op(3'd4, 2'd0, 2'd1, x, e, lat);
      check("pre_rst_err", 32'(e), 1);

      // Asynchronous reset in the second BUSY cycle
      @(negedge clk);
      Q = 3'd7; Y = 2'd3; R = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy_before", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_err",  32'(err),  0);
      check("mid_rst_x",    32'(X),    0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("mid_rst_no_done", 32'(saw_done), 0);
      do_op(3'd1, 2'd1, 2'd0, x, e, lat);
      check("post_rst_x",   32'(x),   1);
      check("post_rst_err", 32'(e),   0);
      check("post_rst_lat", 32'(lat), 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nrad_reconstructor.md
Name: nrad_reconstructor

Overview:
- Sequential shift-and-add multiply-accumulate that rebuilds the dividend from a divider result: X = Q*Y + R.
- It is the inverse path of the team's non-restoring array divider (NRAD). It runs the multiply the divider undoes and self-checks divider outputs in the datapath and in benches.
- Radix-2, one quotient bit per cycle, start/done handshake. Operands are captured at start, so inputs may change while busy.

Parameters:
WQ, 3, quotient width in bits (>=1)
WY, 2, divisor width in bits (>=1); remainder width equals WY

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
Q  input  WQ  quotient operand (multiplier)
Y  input  WY  divisor operand (multiplicand)
R  input  WY  remainder operand (accumulator seed)
X  output  WQ+WY  reconstructed dividend; valid while done=1, held until next accepted start
busy  output  1  1 while computing
done  output  1  one-cycle completion pulse
err  output  1  operand-consistency flag; valid with done, held alongside X

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE.
  - X=0, busy=0, done=0, err=0.
  - All internal registers (acc, mcand, mplier, count) cleared.
  - The operation in flight is abandoned; no done is issued for it.
- States are IDLE, BUSY and DONE.
- IDLE:
  - If start=1 at an edge: acc <= zero-extended R; mcand <= zero-extended Y (WQ+WY bits); mplier <= Q; count <= 0.
  - On the same edge, err_r <= (Y==0) | (R>=Y), busy <= 1, and the state moves to BUSY.
  - If start=0, the state stays IDLE and outputs hold.
- BUSY, one iteration per edge:
  - If mplier[0]=1 then acc <= acc + mcand.
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - On the edge where count==WQ-1 (the WQ-th iteration): state <= DONE, X <= final acc, err <= err_r, busy <= 0, done <= 1.
- DONE: lasts exactly one cycle. Next edge: done <= 0, state <= IDLE. X and err hold.
- Latency:
  - Start accepted at edge k, then done=1 during the cycle following edge k+WQ.
  - busy=1 during the cycles following edges k..k+WQ-1.
  - Throughput is one operation per WQ+2 cycles.
- Start is ignored in BUSY and DONE. There is no queuing, and operands presented then are not captured.
- Width rule: max result (2^WQ-1)(2^WY-1) + (2^WY-1) = (2^WY-1)*2^WQ < 2^(WQ+WY). The accumulator is WQ+WY bits, never overflows, and needs no carry-out.
- Zero operands:
  - Q=0 gives X=R after the full WQ cycles; there is no early termination and latency is fixed.
  - Y=0 gives X=R with err=1.
- err is informational only; the result is always computed as Q*Y+R.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then Q=5, Y=3, R=2, start pulse at edge k:
  - busy=1 for 3 cycles.
  - done=1 one cycle after edge k+3, with X=17 and err=0.
  - done=0 on the next cycle; X stays 17.
- Exhaustive sweep with WQ=3, WY=2: Q=0..7, Y=1..3, R=0..Y-1.
  - Every case gives X = Q*Y + R and err=0.
  - Max case Q=7, Y=3, R=2 gives X=23 (5'b10111).
- Error flags:
  - Q=4, Y=0, R=1 gives X=1, err=1.
  - Q=2, Y=2, R=3 gives X=7, err=1 (R>=Y).
- Start held high continuously, operands changed every cycle while busy:
  - Only operands present at each IDLE accept are used.
  - Back-to-back done pulses are exactly WQ+2=5 cycles apart.
- Reset asserted asynchronously (between edges) in the second BUSY cycle of Q=7, Y=3, R=0:
  - busy, done, err and X drop to 0 immediately.
  - No done follows.
  - A new start for Q=1, Y=1, R=0 yields X=1 after 3 cycles.
- Start asserted during the DONE cycle is ignored:
  - IDLE is entered next, and a start then is accepted normally.
  - Previous X and err are held until the new done.
